imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one unified single-port memory between the instruction-fetch port (IF stage) and the data-memory port (MEM stage).
- Sequences each access with a req/ack handshake and a variable-latency memory ready signal.
- Prioritises data accesses, with starvation protection for fetch and a wait timeout.
- Its ack outputs drive the pipeline stall logic: a stage stalls while its req=1 and ack=0.

Parameters:
- STARVE_MAX, 4: consecutive data grants won against a pending fetch before fetch is forced through; legal range 1..15.
- TIMEOUT, 64: cycles in a wait state without mem_ready before the access is aborted; legal range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_ack.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetched instruction; valid only while if_ack=1.
- if_ack  out  1  one-cycle fetch completion.
- dm_req  in  1  data request; held with dm_* until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_ls  in  4  load/store type code; passed through unmodified.
- dm_rdata  out  32  load data; valid only while dm_ack=1.
- dm_ack  out  1  one-cycle data completion.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_ls  out  4  memory access type.
- mem_rdata  in  32  memory read data; valid while mem_ready=1.
- mem_ready  in  1  memory completion; sampled only while mem_req=1.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, asynchronous) clears the following:
  - state=IDLE;
  - mem_req, mem_we, mem_addr, mem_wdata, mem_ls = 0;
  - starve_cnt = 0, wait_cnt = 0, err = 0;
  - if_ack = dm_ack = 0, if_rdata = dm_rdata = 0.
- Reset mid-access drops mem_req immediately; no ack is issued for the abandoned access.
- FSM states are IDLE, IF_WAIT, DM_WAIT.
- IDLE arbitration on each rising edge:
  - dm_req only: go to DM_WAIT.
  - if_req only: go to IF_WAIT, starve_cnt=0.
  - Both requests:
    - starve_cnt==STARVE_MAX: go to IF_WAIT, starve_cnt=0.
    - Otherwise: go to DM_WAIT, starve_cnt+1.
  - Neither request: stay in IDLE.
- Grant edge actions:
  - Latch the winner's address, write data, we and ls into the mem_* registers.
  - Set mem_req=1 and wait_cnt=0.
  - A fetch grant drives mem_we=0, mem_wdata=0 and mem_ls=4'b0000 (word).
- Wait states (IF_WAIT, DM_WAIT):
  - mem_req=1 and all mem_* outputs stay stable.
  - If mem_ready=1: the owner's ack=1 combinationally in the same cycle, with owner rdata = mem_rdata (store acks still pass mem_rdata). Next edge: mem_req=0, state IDLE.
  - If mem_ready=0: wait_cnt+1. When wait_cnt reaches TIMEOUT-1 with mem_ready still 0: owner ack=1, owner rdata=0, err=1 (sticky until reset). Next edge: IDLE.
- Latency:
  - Minimum request-to-ack is 1 cycle (req sampled at edge N, ack during cycle N+1 if mem_ready=1).
  - Minimum issue interval is 2 cycles, because one IDLE cycle always follows an ack.
- The non-owner's ack is always 0; at most one ack is high in any cycle.
- Requests arriving during a wait are held by the requester and arbitrated in the next IDLE.
- Requester rules: a request raised and dropped before ack is a protocol violation, and behaviour is undefined. A requester may keep req high after ack; this is treated as a new request.
- starve_cnt saturates at STARVE_MAX. It is unchanged on a data grant with no fetch pending.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined, the block adds three 32-bit outputs, each reset to 0 and wrapping modulo 2^32:
  - perf_if_grants: +1 per IF grant.
  - perf_dm_grants: +1 per DM grant.
  - perf_stall_cycles: +1 per cycle where (if_req & ~if_ack) | (dm_req & ~dm_ack).
- When undefined, these ports and counters do not exist and the rest of the behaviour is identical.

Test Plan:
- Single fetch, if_addr=0x0000_0010, mem_ready=1 in the first wait cycle, mem_rdata=0x00A0_0093: if_ack high 1 cycle after the request edge with if_rdata=0x00A0_0093; mem_we=0 throughout.
- Store, dm_addr=0x100, dm_wdata=0xDEAD_BEEF, dm_ls=4'b0010, with mem_ready delayed 3 cycles: mem_* stay stable for 4 cycles, dm_ack pulses exactly once, then one IDLE cycle with mem_req=0.
- if_req and dm_req held continuously, mem_ready=1, STARVE_MAX=4: grant order is DM, DM, DM, DM, IF, DM, ...
- Timeout with TIMEOUT=64 and mem_ready=0: dm_ack asserted with dm_rdata=0 in the 64th wait cycle, err=1, and err stays 1 across subsequent successful accesses.
- rst driven low for 1 cycle during DM_WAIT: mem_req=0 immediately, no dm_ack, starve_cnt=0, next access arbitrates normally.
- With ARB_PERF_CNT_EN defined: 3 fetches plus 2 loads at one wait cycle each give perf_if_grants=3 and perf_dm_grants=2, and perf_stall_cycles matches a bench-side count.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port memory between instruction fetch
// and data access. Data wins arbitration, with a starvation limit that forces
// a pending fetch through, and a timeout that aborts a hung access.
// Optional build macro ARB_PERF_CNT_EN adds grant and stall counters.
module imem_dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_ls,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_ls,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0] perf_if_grants,
  output logic [31:0] perf_dm_grants,
  output logic [31:0] perf_stall_cycles,
`endif
  output logic        err
);

  localparam int unsigned SCW = 4;
  localparam int unsigned WCW = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    DM_WAIT = 2'd2
  } state_t;

  state_t           state;
  logic [SCW-1:0]   starve_cnt;
  logic [WCW-1:0]   wait_cnt;

  logic             dm_grant_c;
  logic             if_grant_c;
  logic             timeout_hit_c;

  // Arbitration decision in IDLE and timeout detection in the wait states.
  always_comb begin
    dm_grant_c    = 1'b0;
    if_grant_c    = 1'b0;
    timeout_hit_c = 1'b0;
    if (state == IDLE) begin
      if (dm_req && (!if_req || (starve_cnt != SCW'(STARVE_MAX)))) begin
        dm_grant_c = 1'b1;
      end else if (if_req) begin
        if_grant_c = 1'b1;
      end
    end else begin
      timeout_hit_c = !mem_ready && (wait_cnt == WCW'(TIMEOUT - 1));
    end
  end

  // Owner ack and read data follow mem_ready in the same cycle; an abort returns zero data.
  always_comb begin
    if_ack   = 1'b0;
    dm_ack   = 1'b0;
    if_rdata = '0;
    dm_rdata = '0;
    if (state == IF_WAIT) begin
      if_ack   = mem_ready || timeout_hit_c;
      if_rdata = mem_ready ? mem_rdata : '0;
    end else if (state == DM_WAIT) begin
      dm_ack   = mem_ready || timeout_hit_c;
      dm_rdata = mem_ready ? mem_rdata : '0;
    end
  end

  // Arbiter FSM with registered memory-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_ls     <= '0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dm_grant_c) begin
            state     <= DM_WAIT;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_ls    <= dm_ls;
            wait_cnt  <= '0;
            // Count a data win only when it actually held off a fetch.
            if (if_req) begin
              starve_cnt <= starve_cnt + SCW'(1);
            end
          end else if (if_grant_c) begin
            state      <= IF_WAIT;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_ls     <= 4'b0000;
            wait_cnt   <= '0;
            starve_cnt <= '0;
          end
        end
        IF_WAIT, DM_WAIT: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end else if (timeout_hit_c) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  // Free-running grant and requester-stall counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_if_grants    <= '0;
      perf_dm_grants    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (if_grant_c) begin
        perf_if_grants <= perf_if_grants + 32'd1;
      end
      if (dm_grant_c) begin
        perf_dm_grants <= perf_dm_grants + 32'd1;
      end
      if ((if_req && !if_ack) || (dm_req && !dm_ack)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: fetch, delayed store, starvation
// order, timeout, mid-access reset and (when built with ARB_PERF_CNT_EN)
// the performance counters.
module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_ls;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_ls;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        err;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_grants;
  logic [31:0] perf_dm_grants;
  logic [31:0] perf_stall_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.STARVE_MAX(4), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ls     (dm_ls),
    .dm_rdata  (dm_rdata),
    .dm_ack    (dm_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ls    (mem_ls),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
`ifdef ARB_PERF_CNT_EN
    .perf_if_grants    (perf_if_grants),
    .perf_dm_grants    (perf_dm_grants),
    .perf_stall_cycles (perf_stall_cycles),
`endif
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

`ifdef ARB_PERF_CNT_EN
  // One access with mem_ready in the first wait cycle; starts and ends at a falling edge.
  task automatic xfer(input bit is_if, input logic [31:0] addr, input logic [31:0] data);
    if (is_if) begin
      if_req  = 1'b1;
      if_addr = addr;
    end else begin
      dm_req  = 1'b1;
      dm_we   = 1'b0;
      dm_addr = addr;
    end
    mem_ready = 1'b1;
    mem_rdata = data;
    @(negedge clk); #1;
    check("perf_xfer_ack", is_if ? if_ack : dm_ack, 1);
    check("perf_xfer_rdata", is_if ? if_rdata : dm_rdata, data);
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
  endtask
`endif

  initial begin
    int stable_bad;
    int acks;
    int ng;
    int both_hi;
    int early;
    logic [5:0] order;

    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_ls = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    order = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_ls", mem_ls, 0);
    check("rst_acks", {if_ack, dm_ack}, 0);
    check("rst_rdata", if_rdata | dm_rdata, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b1;

    // Single fetch, ready in the first wait cycle
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0010;
    mem_ready = 1'b1; mem_rdata = 32'h00A0_0093;
    #1;
    check("t1_idle_ack", if_ack, 0);
    check("t1_idle_mem_req", mem_req, 0);
    @(negedge clk); #1;
    check("t1_if_ack", if_ack, 1);
    check("t1_if_rdata", if_rdata, 32'h00A0_0093);
    check("t1_mem_req", mem_req, 1);
    check("t1_mem_addr", mem_addr, 32'h0000_0010);
    check("t1_mem_we", mem_we, 0);
    check("t1_dm_ack", dm_ack, 0);
    if_req = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("t1_after_mem_req", mem_req, 0);
    check("t1_after_ack", if_ack, 0);

    // Store with ready delayed by three wait cycles
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0100;
    dm_wdata = 32'hDEAD_BEEF; dm_ls = 4'b0010; mem_rdata = 32'h1234_5678;
    stable_bad = 0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) mem_ready = 1'b1;
      #1;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h0000_0100 ||
          mem_wdata !== 32'hDEAD_BEEF || mem_ls !== 4'b0010) stable_bad++;
      if (dm_ack === 1'b1) acks++;
      if (i == 3) begin
        check("t2_ack_cycle", dm_ack, 1);
        check("t2_store_rdata", dm_rdata, 32'h1234_5678);
      end
    end
    dm_req = 1'b0; dm_we = 1'b0;
    check("t2_stable", stable_bad, 0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    if (dm_ack === 1'b1) acks++;
    check("t2_idle_mem_req", mem_req, 0);
    check("t2_ack_once", acks, 1);

    // Both requests held: DM x4 then IF then DM
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0020;
    dm_req = 1'b1; dm_addr = 32'h0000_0200;
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0000;
    ng = 0;
    both_hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (if_ack && dm_ack) both_hi++;
      if (if_ack || dm_ack) begin
        if (ng < 6) order[ng] = if_ack;
        ng++;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    check("t3_grant_count", ng, 6);
    check("t3_grant_order", {26'd0, order}, 32'b01_0000);
    check("t3_one_ack", both_hi, 0);

    // Timeout on a load that never completes
    @(negedge clk);
    mem_ready = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0300;
    mem_rdata = 32'hBADB_AD00;
    early = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); #1;
      if (i < 63) begin
        if (dm_ack === 1'b1) early++;
      end else begin
        check("t4_timeout_ack", dm_ack, 1);
        check("t4_timeout_rdata", dm_rdata, 0);
      end
    end
    dm_req = 1'b0;
    check("t4_no_early_ack", early, 0);
    @(negedge clk); #1;
    check("t4_err_set", err, 1);
    check("t4_mem_req_drop", mem_req, 0);
    if_req = 1'b1; if_addr = 32'h0000_0040;
    mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
    @(negedge clk); #1;
    check("t4_fetch_ack", if_ack, 1);
    check("t4_fetch_rdata", if_rdata, 32'h0000_0013);
    if_req = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("t4_err_sticky", err, 1);

    // Reset during DM_WAIT
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0050;
    dm_req = 1'b1; dm_addr = 32'h0000_0500;
    @(negedge clk); #1;
    check("t5_dm_won", mem_addr, 32'h0000_0500);
    check("t5_in_wait", mem_req, 1);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0055;
    rst = 1'b0;
    #1;
    check("t5_rst_mem_req", mem_req, 0);
    check("t5_rst_no_ack", dm_ack, 0);
    check("t5_rst_starve", dut.starve_cnt, 0);
    check("t5_rst_err", err, 0);
    @(negedge clk); #1;
    check("t5_rst_hold_ack", dm_ack, 0);
    rst = 1'b1;
    if_req = 1'b0;
    @(negedge clk); #1;
    check("t5_post_ack", dm_ack, 1);
    check("t5_post_addr", mem_addr, 32'h0000_0500);
    check("t5_post_rdata", dm_rdata, 32'h0000_0055);
    dm_req = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;

`ifdef ARB_PERF_CNT_EN
    // Performance counters: 3 fetches, 2 loads, one stall cycle each
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xfer(1'b1, 32'h0000_1000, 32'h0000_0A01);
    xfer(1'b0, 32'h0000_2000, 32'h0000_0B01);
    xfer(1'b1, 32'h0000_1004, 32'h0000_0A02);
    xfer(1'b0, 32'h0000_2004, 32'h0000_0B02);
    xfer(1'b1, 32'h0000_1008, 32'h0000_0A03);
    @(negedge clk); #1;
    check("perf_if_grants", perf_if_grants, 3);
    check("perf_dm_grants", perf_dm_grants, 2);
    check("perf_stall_cycles", perf_stall_cycles, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
